div24_seq: RTL
==============

Name: div24_seq

Overview:
- Sequential restoring divider that inverts the 24x24 mantissa multiplier.
- Takes a 2W-bit dividend, for example a 48-bit product, and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder.
- Retires one quotient bit per clock.
- Sits beside the multiplier in the floating-point/inference datapath and feeds mantissa division for normalisation and scaling.

Parameters:
- W, 24, operand width: divisor, quotient and remainder are W bits; the dividend is 2W bits.
- CW, 5, iteration counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept a request.
- in_dividend  input  2W  dividend.
- in_divisor  input  W  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_quotient  output  W  quotient.
- out_remainder  output  W  remainder.
- out_div_zero  output  1  divisor was zero.
- out_overflow  output  1  quotient does not fit in W bits.

Behaviour:
- Reset is asynchronous and active-high on rst; the only clock is clk.
  - Reset forces state IDLE, in_ready=1, out_valid=0, and clears all result registers and flags.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is produced.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: both ready and valid are 0.
  - DONE: out_valid=1, in_ready=0.
- Acceptance is on a rising edge with in_valid & in_ready. On that edge:
  - If in_divisor==0: go to DONE; out_div_zero=1, out_overflow=0, out_quotient all ones, out_remainder=0.
  - Else if in_dividend[2W-1:W] >= in_divisor: go to DONE; out_overflow=1, out_div_zero=0, out_quotient all ones, out_remainder=0.
  - Else: load R = in_dividend[2W-1:W] (W bits), Q = in_dividend[W-1:0], D = in_divisor, cnt=0; go to CALC; both flags cleared.
- CALC step, one per edge:
  - T = {R, Q[W-1]} (W+1 bits); diff = T - {1'b0, D}.
  - If diff is non-negative (borrow=0): R <= diff[W-1:0] and qbit=1. Otherwise R <= T[W-1:0] and qbit=0.
  - Q <= {Q[W-2:0], qbit}; cnt <= cnt+1.
  - On the edge where cnt==W-1, go to DONE.
  - R < D holds throughout, so W+1 bits of T are sufficient.
- Latency:
  - Normal path: out_valid rises exactly W edges after the accept edge (24 for the default W).
  - Error path: out_valid is high in the cycle immediately after the accept edge.
- Result outputs:
  - In DONE, out_quotient=Q and out_remainder=R.
  - Outputs are registered and stay stable while out_valid=1 and out_ready=0 (backpressure is unbounded).
  - The edge with out_valid & out_ready returns the block to IDLE.
  - in_ready=1 in the following cycle; there is no accept in the same cycle as result handoff.
  - Maximum throughput: one result per W+2 cycles.
- Input hold: inputs are sampled only on the accept edge; changes on in_* outside acceptance are ignored.
- Outside DONE, out_quotient, out_remainder and both flags hold their last values; they are only meaningful while out_valid=1.
- Arithmetic is unsigned only. Invariant on the normal path: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package (div_pkg) holds:
  - MANT_W=24;
  - state encoding IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - the all-ones saturation constant.
- One combinational sub-module, div_step: inputs R, the incoming bit and D; outputs the next R and qbit. It keeps the subtract/restore logic isolated and reusable for a later unrolled radix-4 version.
- Top level holds the FSM, counter, handshake and flag logic.

Test Plan:
- Basic: dividend 48'd100, divisor 24'd7 -> quotient 14, remainder 2. out_valid rises 24 cycles after accept; in_ready=0 during CALC.
- Exact, maximum operands: dividend 48'hFFFFFE_000001, divisor 24'hFFFFFF -> quotient 24'hFFFFFF, remainder 0. Also dividend 48'h000001_000000, divisor 2 -> quotient 24'h800000, remainder 0.
- Error flags:
  - Divisor 0 -> out_div_zero=1, quotient 24'hFFFFFF, remainder 0, out_valid one cycle after accept.
  - Dividend 48'h000005_000000 with divisor 5 -> out_overflow=1, same saturated outputs.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs must stay stable and in_ready=0. Release: one handoff edge, then in_ready=1 on the next cycle, and a new request is accepted.
- Reset mid-operation: assert rst at CALC step 10 of 100/7 -> immediately out_valid=0, in_ready=1, outputs 0. A following request (6/3) yields quotient 2, remainder 0 with no stale data.
- Random round-trip against the multiplier: random A, B (B≠0); product S = A*B through mult24, then S / B -> quotient A, remainder 0. Also random dividends checked against a reference model for dividend == q*d + r with r < d, at least 10k vectors.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the mantissa divider
package div_pkg;

  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported on divide-by-zero and quotient overflow
  localparam logic [MANT_W-1:0] SAT_ONES = {MANT_W{1'b1}};

endpackage

// File: rtl/div24_seq_if.sv
// rtl/div24_seq_if.sv - request/result handshake bundle for the divider
interface div24_seq_if #(
  parameter int W = 24
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_dividend;
  logic [W-1:0]   in_divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_quotient;
  logic [W-1:0]   out_remainder;
  logic           out_div_zero;
  logic           out_overflow;

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero, out_overflow
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_zero, out_overflow
  );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a bit, trial subtract, restore
module div_step #(
  parameter int W = 24
) (
  input  logic [W-1:0] r_i,
  input  logic         bit_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic         qbit_o
);

  logic [W:0]   t;
  logic [W+1:0] diff;

  // Trial subtract with one spare bit so the borrow lands in the MSB; R < D keeps T within W+1 bits
  always_comb begin
    t      = {r_i, bit_i};
    diff   = {1'b0, t} - {2'b00, d_i};
    qbit_o = ~diff[W+1];
    r_o    = qbit_o ? diff[W-1:0] : t[W-1:0];
  end

endmodule

// File: rtl/div24_seq.sv
// rtl/div24_seq.sv - sequential restoring divider, 2W/W -> W quotient and W remainder
module div24_seq
  import div_pkg::*;
#(
  parameter int W  = MANT_W,
  parameter int CW = 5
) (
  input  logic       clk,
  input  logic       rst,
  div24_seq_if.slave bus
);

  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  div_state_e    state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  r_next;
  logic          qbit;

  div_step #(.W(W)) u_step (
    .r_i    (r_q),
    .bit_i  (q_q[W-1]),
    .d_i    (d_q),
    .r_o    (r_next),
    .qbit_o (qbit)
  );

  // Next-state, datapath and result-register load decisions
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_divisor == '0) begin
            state_d = DONE;
            quo_d   = ALL_ONES;
            rem_d   = '0;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else if (bus.in_dividend[2*W-1:W] >= bus.in_divisor) begin
            state_d = DONE;
            quo_d   = ALL_ONES;
            rem_d   = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = bus.in_dividend[2*W-1:W];
            q_d     = bus.in_dividend[W-1:0];
            d_d     = bus.in_divisor;
            cnt_d   = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      CALC: begin
        r_d   = r_next;
        q_d   = {q_q[W-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          quo_d   = {q_q[W-2:0], qbit};
          rem_d   = r_next;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and held result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake strobes decode straight from the state register
  always_comb begin
    bus.in_ready      = (state_q == IDLE);
    bus.out_valid     = (state_q == DONE);
    bus.out_quotient  = quo_q;
    bus.out_remainder = rem_q;
    bus.out_div_zero  = dz_q;
    bus.out_overflow  = ovf_q;
  end

endmodule
